// File: rtl/mux_scan_sequencer_if.sv
// Sample delivery channel from the scan sequencer to its consumer.
// The master presents DATA/CH with VALID; the slave accepts by raising READY.
interface mux_scan_sequencer_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] DATA;
    logic [2:0]       CH;
    logic             VALID;
    logic             READY;

    modport master (output DATA, output CH, output VALID, input READY);
    modport slave  (input DATA, input CH, input VALID, output READY);
endinterface

// File: rtl/mux_scan_sequencer.sv
// Walks the enabled channels of an 8:1 mux in ascending order, lets each select settle
// for DWELL cycles, captures Q and hands the sample downstream over valid/ready.
module mux_scan_sequencer #(
    parameter int WIDTH = 4,
    parameter int DWELL = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic [7:0]            MASK,
    input  logic [WIDTH-1:0]      Q,
    output logic [2:0]            S,
    output logic                  BUSY,
    output logic                  DONE,
    mux_scan_sequencer_if.master  out_if
);
    typedef enum logic [1:0] {IDLE, SETTLE, OUT, FIN} state_t;

    localparam logic [3:0] DWELL_LOAD = 4'(DWELL - 1);

    state_t           state_q, state_d;
    logic [7:0]       mask_q, mask_d;
    logic [2:0]       s_q, s_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [2:0]       ch_q, ch_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [3:0]       cnt_q, cnt_d;

    logic [7:0]       above_mask;
    logic             has_next;
    logic [2:0]       next_ch;

    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (v[k]) idx = 3'(k);
        end
        return idx;
    endfunction

    // Latched channels strictly above the one just delivered; no wrap-around.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_above
            assign above_mask[gi] = mask_q[gi] && (3'(gi) > ch_q);
        end
    endgenerate

    assign has_next = |above_mask;
    assign next_ch  = lowest_set(above_mask);

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        s_d     = s_q;
        data_d  = data_q;
        ch_d    = ch_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (START) begin
                    busy_d = 1'b1;
                    if (|MASK) begin
                        mask_d  = MASK;
                        s_d     = lowest_set(MASK);
                        cnt_d   = DWELL_LOAD;
                        state_d = SETTLE;
                    end else begin
                        done_d  = 1'b1;
                        state_d = FIN;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    data_d  = Q;
                    ch_d    = s_q;
                    valid_d = 1'b1;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (out_if.READY) begin
                    valid_d = 1'b0;
                    if (has_next) begin
                        s_d     = next_ch;
                        cnt_d   = DWELL_LOAD;
                        state_d = SETTLE;
                    end else begin
                        done_d  = 1'b1;
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                busy_d  = 1'b0;
                s_d     = 3'd0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            mask_q  <= 8'd0;
            s_q     <= 3'd0;
            data_q  <= '0;
            ch_q    <= 3'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            s_q     <= s_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign S            = s_q;
    assign BUSY         = busy_q;
    assign DONE         = done_q;
    assign out_if.DATA  = data_q;
    assign out_if.CH    = ch_q;
    assign out_if.VALID = valid_q;
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Randomized bench for mux_scan_sequencer; an event-level model predicts sample order,
// capture timing and handshake behaviour from the mask, DWELL and the READY pattern.
module tb_mux_scan_sequencer;
    localparam int WIDTH = 4;
    localparam int D     = 2;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             START;
    logic [7:0]       MASK;
    logic [WIDTH-1:0] Q;
    logic [2:0]       S;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] i_vals [8];

    int checks   = 0;
    int failures = 0;

    mux_scan_sequencer_if #(.WIDTH(WIDTH)) bus ();

    mux_scan_sequencer #(.WIDTH(WIDTH), .DWELL(D)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .START  (START),
        .MASK   (MASK),
        .Q      (Q),
        .S      (S),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .out_if (bus)
    );

    always #5 CLK = ~CLK;

    // Mux8x1 stand-in: Q = I[S]
    assign Q = i_vals[S];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_s"},     S, 0);
        check_eq({tag, "_data"},  bus.DATA, 0);
        check_eq({tag, "_ch"},    bus.CH, 0);
        check_eq({tag, "_valid"}, bus.VALID, 0);
        check_eq({tag, "_busy"},  BUSY, 0);
        check_eq({tag, "_done"},  DONE, 0);
    endtask

    // Called and returns at a falling edge. stall_ch forces READY low for 5 offered cycles on that channel.
    task automatic run_scan(input logic [7:0] m, input int ready_pct, input int stall_ch, input bit extra_start);
        int   chans[$];
        int   idx, next_cap, fin_c, stall_n, last_ch;
        bit   done_run;
        logic exp_valid;
        idx = 0; next_cap = D; fin_c = -1; stall_n = 0; done_run = 0; last_ch = 0;
        for (int k = 0; k < 8; k++) if (m[k]) chans.push_back(k);
        if (chans.size() == 0) fin_c = 0;
        START = 1'b1;
        MASK = m;
        bus.READY = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        MASK = 8'($urandom);
        for (int c = 0; c < 400 && !done_run; c++) begin
            START = 1'b0;
            exp_valid = 1'b0;
            if (idx < chans.size()) begin
                exp_valid = (c >= next_cap);
                check_eq("busy", BUSY, 1);
                check_eq("done", DONE, 0);
                check_eq("s", S, chans[idx]);
                check_eq("valid", bus.VALID, exp_valid);
                if (exp_valid) begin
                    check_eq("ch", bus.CH, chans[idx]);
                    check_eq("data", bus.DATA, i_vals[chans[idx]]);
                end
            end else if (c == fin_c) begin
                check_eq("fin_done", DONE, 1);
                check_eq("fin_busy", BUSY, 1);
                check_eq("fin_valid", bus.VALID, 0);
                check_eq("fin_s", S, last_ch);
            end else begin
                check_eq("idle_done", DONE, 0);
                check_eq("idle_busy", BUSY, 0);
                check_eq("idle_valid", bus.VALID, 0);
                check_eq("idle_s", S, 0);
                done_run = 1;
            end
            bus.READY = ($urandom_range(99) < ready_pct);
            if (exp_valid && chans[idx] == stall_ch && stall_n < 5) begin
                bus.READY = 1'b0;
                stall_n++;
            end
            if (extra_start && c == 1 && idx < chans.size()) START = 1'b1;
            MASK = 8'($urandom);
            if (exp_valid && bus.READY) begin
                $display("txn mask=%02h ch=%0d data=%0h cycle=%0d", m, chans[idx], i_vals[chans[idx]], c + 1);
                last_ch = chans[idx];
                idx++;
                if (idx == chans.size()) fin_c = c + 1;
                else next_cap = c + 1 + D;
            end
            @(negedge CLK);
        end
        check_eq("scan_finished", done_run, 1);
        repeat (2) begin
            check_eq("post_done", DONE, 0);
            check_eq("post_busy", BUSY, 0);
            @(negedge CLK);
        end
    endtask

    initial begin
        for (int k = 0; k < 8; k++) i_vals[k] = 4'(k);
        RESET = 1'b1;
        START = 1'($urandom);
        MASK = 8'($urandom);
        bus.READY = 1'($urandom);
        @(posedge CLK);
        @(negedge CLK);
        START = 1'($urandom);
        MASK = 8'($urandom);
        bus.READY = 1'($urandom);
        @(posedge CLK);
        @(negedge CLK);
        check_all_zero("reset");
        RESET = 1'b0;
        START = 1'b0;
        bus.READY = 1'b0;
        @(negedge CLK);

        run_scan(8'hFF, 100, -1, 0);
        run_scan(8'hA5, 100, -1, 0);
        run_scan(8'hFF, 100, 2, 0);
        run_scan(8'h00, 100, -1, 0);
        run_scan(8'hFF, 100, -1, 1);

        // Reset in the middle of channel 3's settle window.
        START = 1'b1;
        MASK = 8'h08;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
        check_eq("pre_rst_s", S, 3);
        check_eq("pre_rst_busy", BUSY, 1);
        RESET = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        check_all_zero("midrst");
        @(negedge CLK);
        check_all_zero("midrst_idle");
        run_scan(8'h08, 100, -1, 0);

        for (int t = 0; t < 12; t++) begin
            for (int k = 0; k < 8; k++) i_vals[k] = 4'($urandom);
            run_scan(8'($urandom), $urandom_range(20, 100),
                     ($urandom_range(1) == 1) ? int'($urandom_range(7)) : -1,
                     1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
